// File: rtl/regbus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regbus_pkg : shared source-select encodings and address range check |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package regbus_pkg;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_DIN  = 2'b01;
  localparam logic [1:0] SRC_FOUT = 2'b10;
  localparam logic [1:0] SRC_HOLD = 2'b11;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned nregs);
    return (addr < nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regbus_file.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regbus_file : NREGS x WIDTH storage, one sync write, one async read |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module regbus_file
  import regbus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_oor,
  output logic             wr_oor
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_wr_ok = addr_in_range(32'(wr_addr), NREGS);
  assign w_rd_ok = addr_in_range(32'(rd_addr), NREGS);
  assign wr_oor  = ~w_wr_ok;
  assign rd_oor  = ~w_rd_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en && w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  // Out-of-range reads return zero rather than an undefined entry.
  always_comb begin
    rd_data = '0;
    if (w_rd_ok) begin
      rd_data = r_regs[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regbus_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regbus_mux : registered bus source select over an internal regfile |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module regbus_mux
  import regbus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       src_sel,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] fout,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] bus_q,
  output logic             bus_vld,
  output logic             addr_err
);

  logic [WIDTH-1:0] r_bus_q;
  logic             r_bus_vld;
  logic             r_addr_err;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_rd_oor;
  logic             w_wr_oor;
  logic [WIDTH-1:0] w_src;
  logic             w_bypass;
  logic             w_err;

  regbus_file #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (r_bus_q),
    .rd_addr (rd_addr),
    .rd_data (w_rd_data),
    .rd_oor  (w_rd_oor),
    .wr_oor  (w_wr_oor)
  );

  // A same-address write this edge carries bus_q, so forward it instead of the stale entry.
  assign w_bypass = wr_en && (rd_addr == wr_addr) && !w_rd_oor;

  always_comb begin
    w_src = '0;
    case (src_sel)
      SRC_REG:  w_src = w_bypass ? r_bus_q : w_rd_data;
      SRC_DIN:  w_src = din;
      SRC_FOUT: w_src = fout;
      SRC_HOLD: w_src = r_bus_q;
      default:  w_src = '0;
    endcase
  end

  assign w_err = (rd_en && (src_sel == SRC_REG) && w_rd_oor) || (wr_en && w_wr_oor);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_q    <= '0;
      r_bus_vld  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_bus_vld  <= rd_en;
      r_addr_err <= w_err;
      if (rd_en) begin
        r_bus_q <= w_src;
      end
    end
  end

  assign bus_q    = r_bus_q;
  assign bus_vld  = r_bus_vld;
  assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_regbus_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regbus_mux : directed self-checking bench, NREGS=6 / AW=3       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_regbus_mux;
  import regbus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] src_sel;
  logic [2:0] rd_addr;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] fout;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] bus_q;
  logic       bus_vld;
  logic       addr_err;

  int nchk;
  int npass;
  logic [7:0] exp_regs [6];

  regbus_mux #(.WIDTH(8), .NREGS(6), .AW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_sel  (src_sel),
    .rd_addr  (rd_addr),
    .rd_en    (rd_en),
    .din      (din),
    .fout     (fout),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .bus_q    (bus_q),
    .bus_vld  (bus_vld),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_n   = 1'b0;
      src_sel = 2'($urandom);
      rd_addr = 3'($urandom);
      rd_en   = 1'($urandom);
      din     = 8'($urandom);
      fout    = 8'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = 3'($urandom);
      cyc();
    end
    nchk++; if (bus_q !== 8'h00) $display("FAIL reset_bus_q got %h want 00", bus_q); else npass++;
    nchk++; if (bus_vld !== 1'b0) $display("FAIL reset_bus_vld got %b want 0", bus_vld); else npass++;
    nchk++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", addr_err); else npass++;
    rst_n = 1'b1;
    idle();
    din = 8'hFF;
    cyc();
    for (int a = 0; a < 6; a++) begin
      src_sel = SRC_REG;
      rd_addr = 3'(a);
      rd_en   = 1'b1;
      cyc();
      nchk++;
      if (bus_q !== 8'h00 || bus_vld !== 1'b1 || addr_err !== 1'b0)
        $display("FAIL reset_read[%0d] got bus=%h vld=%b err=%b want 00/1/0", a, bus_q, bus_vld, addr_err);
      else npass++;
    end
    idle();
  endtask

  task automatic test_load_writeback();
    src_sel = SRC_DIN; din = 8'hA5; rd_en = 1'b1;
    cyc();
    nchk++; if (bus_q !== 8'hA5 || bus_vld !== 1'b1) $display("FAIL load_din got %h/%b want A5/1", bus_q, bus_vld); else npass++;
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd3;
    cyc();
    exp_regs[3] = 8'hA5;
    nchk++; if (bus_q !== 8'hA5 || bus_vld !== 1'b0) $display("FAIL wb_cycle got %h/%b want A5/0", bus_q, bus_vld); else npass++;
    wr_en = 1'b0; src_sel = SRC_DIN; din = 8'h00; rd_en = 1'b1;
    cyc();
    src_sel = SRC_REG; rd_addr = 3'd3;
    cyc();
    nchk++; if (bus_q !== 8'hA5 || bus_vld !== 1'b1) $display("FAIL readback_r3 got %h/%b want A5/1", bus_q, bus_vld); else npass++;
    idle();
  endtask

  task automatic test_bypass();
    src_sel = SRC_DIN; din = 8'h3C; rd_en = 1'b1;
    cyc();
    src_sel = SRC_REG; rd_addr = 3'd5; wr_en = 1'b1; wr_addr = 3'd5;
    cyc();
    exp_regs[5] = 8'h3C;
    nchk++; if (bus_q !== 8'h3C || bus_vld !== 1'b1) $display("FAIL bypass got %h/%b want 3C/1", bus_q, bus_vld); else npass++;
    wr_en = 1'b0; src_sel = SRC_DIN; din = 8'h00;
    cyc();
    src_sel = SRC_REG; rd_addr = 3'd5;
    cyc();
    nchk++; if (bus_q !== 8'h3C) $display("FAIL bypass_r5 got %h want 3C", bus_q); else npass++;
    // different-address read and write in one cycle
    src_sel = SRC_REG; rd_addr = 3'd3; wr_en = 1'b1; wr_addr = 3'd1;
    cyc();
    exp_regs[1] = 8'h3C;
    nchk++; if (bus_q !== 8'hA5) $display("FAIL split_rw got %h want A5", bus_q); else npass++;
    wr_en = 1'b0; rd_addr = 3'd1;
    cyc();
    nchk++; if (bus_q !== 8'h3C) $display("FAIL split_r1 got %h want 3C", bus_q); else npass++;
    idle();
  endtask

  task automatic test_hold_valid();
    src_sel = SRC_FOUT; fout = 8'h7E; rd_en = 1'b1;
    cyc();
    nchk++; if (bus_q !== 8'h7E || bus_vld !== 1'b1) $display("FAIL fout got %h/%b want 7E/1", bus_q, bus_vld); else npass++;
    rd_en = 1'b0; fout = 8'h11;
    cyc();
    nchk++; if (bus_q !== 8'h7E || bus_vld !== 1'b0) $display("FAIL idle_hold got %h/%b want 7E/0", bus_q, bus_vld); else npass++;
    src_sel = SRC_HOLD; rd_en = 1'b1;
    cyc();
    nchk++; if (bus_q !== 8'h7E || bus_vld !== 1'b1) $display("FAIL src_hold got %h/%b want 7E/1", bus_q, bus_vld); else npass++;
    idle();
  endtask

  task automatic test_range();
    src_sel = SRC_REG; rd_addr = 3'd7; rd_en = 1'b1;
    cyc();
    nchk++;
    if (bus_q !== 8'h00 || bus_vld !== 1'b1 || addr_err !== 1'b1)
      $display("FAIL rd_oor got bus=%h vld=%b err=%b want 00/1/1", bus_q, bus_vld, addr_err);
    else npass++;
    idle();
    cyc();
    nchk++; if (addr_err !== 1'b0) $display("FAIL rd_oor_pulse got %b want 0", addr_err); else npass++;
    src_sel = SRC_DIN; rd_addr = 3'd7; din = 8'h99; rd_en = 1'b1;
    cyc();
    nchk++; if (addr_err !== 1'b0 || bus_q !== 8'h99) $display("FAIL din_ignores_addr got err=%b bus=%h want 0/99", addr_err, bus_q); else npass++;
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd6;
    cyc();
    nchk++; if (addr_err !== 1'b1) $display("FAIL wr_oor got %b want 1", addr_err); else npass++;
    idle();
    cyc();
    nchk++; if (addr_err !== 1'b0) $display("FAIL wr_oor_pulse got %b want 0", addr_err); else npass++;
    src_sel = SRC_DIN; din = 8'h55; rd_en = 1'b1;
    cyc();
    src_sel = SRC_REG; rd_addr = 3'd7; wr_en = 1'b1; wr_addr = 3'd6;
    cyc();
    nchk++; if (addr_err !== 1'b1 || bus_q !== 8'h00) $display("FAIL both_oor got err=%b bus=%h want 1/00", addr_err, bus_q); else npass++;
    idle();
    cyc();
    nchk++; if (addr_err !== 1'b0) $display("FAIL both_oor_pulse got %b want 0", addr_err); else npass++;
    for (int a = 0; a < 6; a++) begin
      src_sel = SRC_REG; rd_addr = 3'(a); rd_en = 1'b1;
      cyc();
      nchk++;
      if (bus_q !== exp_regs[a] || addr_err !== 1'b0)
        $display("FAIL regs_intact[%0d] got %h err=%b want %h/0", a, bus_q, addr_err, exp_regs[a]);
      else npass++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    src_sel = SRC_DIN; din = 8'h66; rd_en = 1'b1;
    cyc();
    rst_n = 1'b0; din = 8'h77; wr_en = 1'b1; wr_addr = 3'd2;
    cyc();
    nchk++;
    if (bus_q !== 8'h00 || bus_vld !== 1'b0 || addr_err !== 1'b0)
      $display("FAIL mid_reset got bus=%h vld=%b err=%b want 00/0/0", bus_q, bus_vld, addr_err);
    else npass++;
    rst_n = 1'b1;
    idle();
    cyc();
    for (int a = 0; a < 6; a++) exp_regs[a] = 8'h00;
    for (int a = 1; a < 4; a++) begin
      src_sel = SRC_REG; rd_addr = 3'(a); rd_en = 1'b1;
      cyc();
      nchk++; if (bus_q !== exp_regs[a]) $display("FAIL mid_reset_r%0d got %h want 00", a, bus_q); else npass++;
    end
    idle();
  endtask

  initial begin
    nchk = 0; npass = 0;
    for (int a = 0; a < 6; a++) exp_regs[a] = 8'h00;
    rst_n = 1'b0; src_sel = SRC_REG; rd_addr = '0; rd_en = 1'b0;
    din = '0; fout = '0; wr_en = 1'b0; wr_addr = '0;
    test_reset();
    test_load_writeback();
    test_bypass();
    test_hold_valid();
    test_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbus_mux.md
Name: regbus_mux

Overview:
- Parametrised successor to the datapath's combinational 8-register bus source select.
- Holds an internal register file of NREGS x WIDTH and selects one bus source per cycle: a register, external data in, or the ALU result.
- Drives a registered bus output with a valid flag.
- Supports a bus-to-register write-back path with read/write bypass, defined behaviour for every select encoding, and address-error reporting.

Parameters:
- WIDTH, 8, data width of registers, din, fout and bus.
- NREGS, 8, number of internal registers (2..256; need not be a power of two).
- AW, 3, register address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- src_sel  input  2  bus source: 00 REG, 01 DIN, 10 FOUT, 11 HOLD.
- rd_addr  input  AW  register index used when src_sel=REG.
- rd_en  input  1  load bus_q this cycle.
- din  input  WIDTH  external data source.
- fout  input  WIDTH  ALU result source.
- wr_en  input  1  write bus_q into regs[wr_addr] at this edge.
- wr_addr  input  AW  write-back index.
- bus_q  output  WIDTH  registered bus value.
- bus_vld  output  1  bus_q was loaded at the previous edge.
- addr_err  output  1  one-cycle pulse on an out-of-range access.

Behaviour:
- Reset is synchronous, active-low, and takes priority over all other inputs:
  - regs[*] = 0, bus_q = 0, bus_vld = 0, addr_err = 0.
  - Reset mid-operation discards any pending write and read in that cycle.
- Source value (combinational, internal):
  - REG: regs[rd_addr].
  - DIN: din.
  - FOUT: fout.
  - HOLD: bus_q.
- Read path, latency 1:
  - rd_en=1: bus_q <= source value and bus_vld <= 1.
  - rd_en=0: bus_q holds and bus_vld <= 0.
- Write path:
  - wr_en=1 with wr_addr < NREGS: regs[wr_addr] <= bus_q (old bus_q, pre-edge).
  - No other write source exists; a register loads from din or fout via a read-then-write sequence.
- Bypass: when rd_en=1, src_sel=REG, wr_en=1 and rd_addr==wr_addr in the same cycle, the source value is bus_q, i.e. the write-through value, not the stale register.
- Simultaneous read and write to different addresses proceed independently.
- Out-of-range rd_addr (>= NREGS) with src_sel=REG and rd_en=1:
  - Source value is 0; bus_q <= 0 and bus_vld <= 1.
  - addr_err <= 1 for one cycle.
- Out-of-range wr_addr with wr_en=1:
  - Write is suppressed; addr_err <= 1.
- Both out of range in the same cycle: a single addr_err pulse.
- addr_err <= 0 in every other cycle.
- rd_addr is ignored for non-REG sources, and never raises addr_err.
- Register contents persist indefinitely without writes; there is no clear except reset.

Decomposition:
- Package regbus_pkg:
  - localparams SRC_REG=2'b00, SRC_DIN=2'b01, SRC_FOUT=2'b10, SRC_HOLD=2'b11.
  - function for the address range check.
- Sub-module regbus_file: NREGS x WIDTH storage with one synchronous write port and one asynchronous read port, including the range check. The top level holds the source mux, bypass, bus_q, bus_vld and addr_err.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with random inputs -> bus_q=0, bus_vld=0, addr_err=0; REG read of every address returns 0.
- Load and write-back (WIDTH=8):
  - Cycle 0: src_sel=DIN, din=8'hA5, rd_en=1 -> bus_q=A5, bus_vld=1 at cycle 1.
  - Cycle 1: wr_en=1, wr_addr=3 -> regs[3]=A5.
  - Later REG read of addr 3 -> bus_q=A5 one cycle after request.
- Bypass: bus_q=8'h3C; same cycle wr_en=1, wr_addr=5, src_sel=REG, rd_addr=5, rd_en=1 (regs[5]=8'h00) -> next bus_q=3C, regs[5]=3C.
- Hold and valid:
  - src_sel=FOUT, fout=8'h7E, rd_en=1 -> bus_q=7E.
  - Then rd_en=0 with fout changing -> bus_q stays 7E, bus_vld=0.
  - Then src_sel=HOLD, rd_en=1 -> bus_q=7E, bus_vld=1.
- Range errors (NREGS=6, AW=3):
  - REG read of rd_addr=7 -> bus_q=0, addr_err pulse of exactly 1 cycle.
  - wr_en to wr_addr=6 -> no register changes, single addr_err pulse.
  - Both in one cycle -> one pulse.
- Reset mid-operation: wr_en=1, rd_en=1 asserted in the same cycle as rst_n=0 -> regs unchanged from 0, bus_q=0, bus_vld=0.
